// File: rtl/maze_pkg.sv
// Types and defaults shared by the maze solver and its path streamer.
package maze_pkg;

  localparam int DEFAULT_SIZE = 9;
  localparam int DEFAULT_N    = 4;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } stream_state_t;

  typedef enum logic [2:0] {
    RIGHT,
    LEFT,
    DOWN,
    UP,
    NONE
  } dir_t;

endpackage

// File: rtl/maze_popcount.sv
// Combinational population count of a W-bit vector.
module maze_popcount #(
  parameter int W = 81
) (
  input  logic [W-1:0]             bits,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int CNT_W = $clog2(W+1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/maze_path_streamer.sv
// Snapshots the solver's path bitmap on a done edge and streams every visited
// cell's (x,y) row-major over valid/ready, flagging the last beat.
module maze_path_streamer
  import maze_pkg::*;
#(
  parameter int size = DEFAULT_SIZE,
  parameter int N    = DEFAULT_N,
  parameter int CW   = 2*N
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           done_in,
  input  logic [size-1:0][size-1:0]      path,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N-1:0]                   out_x,
  output logic [N-1:0]                   out_y,
  output logic                           out_last,
  output logic [CW-1:0]                  total_cells,
  output logic                           busy,
  output logic                           complete
);

  localparam int CELLS = size*size;
  localparam int PW    = $clog2(CELLS+1);
  localparam int IW    = $clog2(CELLS);

  stream_state_t   state;
  logic            done_q;
  logic [CELLS-1:0] snap;
  logic [IW-1:0]   idx;
  logic [N-1:0]    cx, cy;
  logic [CW-1:0]   emitted;
  logic [PW-1:0]   pop;
  logic            capture, accept, stall;
  logic [CW-1:0]   emitted_acc;

  maze_popcount #(.W(CELLS)) u_pop (
    .bits  (path),
    .count (pop)
  );

  assign capture     = (state == IDLE) && done_in && !done_q;
  assign accept      = out_valid && out_ready;
  assign stall       = out_valid && !out_ready;
  assign emitted_acc = emitted + CW'(accept);

  // Snapshot is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (capture) snap <= path;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      done_q      <= 1'b1;
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      out_last    <= 1'b0;
      total_cells <= '0;
      busy        <= 1'b0;
      complete    <= 1'b0;
      idx         <= '0;
      cx          <= '0;
      cy          <= '0;
      emitted     <= '0;
    end else begin
      done_q   <= done_in;
      complete <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            total_cells <= CW'(pop);
            idx         <= '0;
            cx          <= '0;
            cy          <= '0;
            emitted     <= '0;
            if (pop == '0) begin
              complete <= 1'b1;
            end else begin
              state <= SCAN;
              busy  <= 1'b1;
            end
          end
        end
        SCAN: begin
          emitted <= emitted_acc;
          if (!stall) begin
            if (snap[idx]) begin
              out_valid <= 1'b1;
              out_x     <= cx;
              out_y     <= cy;
              out_last  <= (emitted_acc + CW'(1) == total_cells);
            end else if (accept) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
            if (idx == IW'(CELLS-1)) begin
              state <= DRAIN;
            end else begin
              idx <= idx + IW'(1);
              if (cx == N'(size-1)) begin
                cx <= '0;
                cy <= cy + N'(1);
              end else begin
                cx <= cx + N'(1);
              end
            end
          end
        end
        DRAIN: begin
          // The final beat may already have been taken while scanning trailing empty cells.
          if (!out_valid || out_ready) begin
            emitted   <= emitted_acc;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            complete  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/maze_path_streamer.md
Name: maze_path_streamer

Overview:
Downstream consumer of the maze wall-follower. It snapshots the solver's size x size path bitmap when the solver's done flag rises. It then scans the snapshot row-major and streams every visited cell's (x,y) coordinate over a valid/ready interface, flagging the final beat and reporting the total visited-cell count. It decouples the solver from slow sinks such as a UART or display writer.

Parameters:
size, 9, maze edge length in cells; the bitmap is size x size, indexed path[y][x]
N, 4, coordinate width; must satisfy 2**N >= size
CW, 2*N, width of cell counters; must satisfy 2**CW > size*size

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
done_in  input  1  solver done flag; level signal, stays high until solver reset
path  input  [size-1:0] x size  solver visited bitmap, path[y][x]; only sampled at capture
out_valid  output  1  coordinate beat valid
out_ready  input  1  sink accepts beat when out_valid && out_ready at clk edge
out_x  output  N  column of streamed cell
out_y  output  N  row of streamed cell
out_last  output  1  high with the final beat of a stream
total_cells  output  CW  popcount of captured snapshot, valid from the cycle after capture
busy  output  1  high in SCAN or DRAIN
complete  output  1  one-cycle pulse when the stream has fully drained

Behaviour:
- Reset values (async, immediate): state=IDLE, out_valid=0, out_x=0, out_y=0, out_last=0, total_cells=0, busy=0, complete=0, idx=0, emitted=0, done_q=1.
- done_q registers done_in every cycle. Its reset value of 1 means a done_in held high through reset does NOT trigger a capture; a fresh 0->1 edge is required.
- States: IDLE, SCAN, DRAIN.
- IDLE: on edge with done_in && !done_q, perform capture:
  - snap <= path
  - total_cells <= popcount(path), computed combinationally and zero-extended to CW
  - idx <= 0, emitted <= 0
  - if popcount==0: stay IDLE and pulse complete next cycle; no beats emitted
  - else: go to SCAN
- Output stall condition: stall = out_valid && !out_ready. A beat is accepted on any edge where out_valid && out_ready; on acceptance emitted increments.
- SCAN: examines cell idx, where y = idx / size and x = idx % size, ordered row 0 first and x ascending within a row.
  - If stall: hold idx and all outputs.
  - Else if snap cell is set: load out_x, out_y and out_valid=1; set out_last=1 iff this is the total_cells-th beat (emitted-after-accept + 1 == total_cells). Advance idx.
  - Else if the current beat was accepted and no new cell is loaded: clear out_valid and out_last.
  - Unset cells advance idx with no output. Cost is one cycle per cell.
  - Once idx == size*size-1 has been handled, go to DRAIN.
- DRAIN: hold the last beat until it is accepted. On acceptance: out_valid=0, out_last=0, complete=1 for one cycle, then IDLE.
- Output register rules:
  - out_x, out_y and out_last are stable while out_valid && !out_ready.
  - out_valid never drops without acceptance.
  - No combinational path from out_ready to any output.
- Throughput: a back-to-back beat per cycle is possible when set cells are adjacent in scan order and out_ready=1.
- Latency: the first beat appears at the earliest 2 cycles after the done_in rising edge is sampled (cell 0 set).
- The path input may change after capture; only snap is used.
- A done_in edge during SCAN or DRAIN is ignored. done_q still tracks it, so no spurious re-capture occurs.
- rst mid-stream aborts immediately. Partial streams are not resumed, and complete is not pulsed.
- Invariant: exactly total_cells beats per capture, with out_last on the final beat only.

Decomposition:
- Shared package maze_pkg holds:
  - stream state enum {IDLE,SCAN,DRAIN}
  - direction constants RIGHT/LEFT/DOWN/UP/NONE, shared with the solver
  - default size and N
- One natural sub-module: maze_popcount (parameter W, input [W-1:0] bits, output count), purely combinational, used for total_cells.

Test Plan:
1. Reset asserted with done_in=1 and then released -> all outputs 0, no capture until done_in toggles 0->1.
2. Path bits (1,0),(1,1),(2,1) set, out_ready=1, done_in rises -> beats (x=1,y=0), (1,1), (2,1); out_last only on (2,1); total_cells=3; complete pulses the cycle after the last acceptance.
3. Same path with out_ready=0 for 5 cycles while first beat is valid -> out_x=1, out_y=0 held stable, out_valid stays 1, then all 3 beats delivered in order with no loss or duplication.
4. All-zero path, done_in rises -> out_valid never asserts, total_cells=0, complete pulses once, busy stays 0.
5. All 81 bits set, out_ready=1 -> 81 consecutive beats from (0,0) to (8,8); out_last on (8,8) only; total_cells=81; second done_in edge mid-stream has no effect.
6. rst pulse after 10 beats of case 5 -> out_valid=0 immediately; after release with done_in still 1, no beats; done_in 0->1 -> fresh stream starting at (0,0).
